// File: rtl/rat_io_port_hub_if.sv
// CPU port bus between the RAT core and the I/O hub.
// Handshake: io_strb qualifies a one-cycle write of out_port to port_id; reads need no
// handshake, since in_port follows port_id combinationally. intr is a one-cycle pulse.
interface rat_io_port_hub_if;
    logic [7:0] port_id;
    logic [7:0] out_port;
    logic       io_strb;
    logic [7:0] in_port;
    logic       intr;

    modport master (
        output port_id,
        output out_port,
        output io_strb,
        input  in_port,
        input  intr
    );

    modport slave (
        input  port_id,
        input  out_port,
        input  io_strb,
        output in_port,
        output intr
    );
endinterface

// File: rtl/rat_io_port_hub.sv
// RAT CPU I/O hub: output registers, input channels, keyboard scancode FIFO with
// interrupt, and a framebuffer write port with optional address auto-increment.
module rat_io_port_hub #(
    parameter int         NUM_OUT    = 4,
    parameter logic [7:0] OUT_BASE   = 8'h40,
    parameter int         NUM_IN     = 4,
    parameter logic [7:0] IN_BASE    = 8'h20,
    parameter int         FIFO_DEPTH = 8,
    parameter int         FB_X_MAX   = 79,
    parameter int         FB_Y_MAX   = 59
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rat_io_port_hub_if.slave      bus,
    input  logic [8*NUM_IN-1:0]   in_data,
    output logic [8*NUM_OUT-1:0]  out_regs,
    input  logic                  kbd_valid,
    input  logic [7:0]            kbd_code,
    output logic [12:0]           fb_wa,
    output logic [7:0]            fb_wd,
    output logic                  fb_we,
    input  logic [7:0]            fb_rd
);

    localparam logic [7:0] KBD_DATA = 8'h44;
    localparam logic [7:0] KBD_STAT = 8'h45;
    localparam logic [7:0] CTRL     = 8'h46;
    localparam logic [7:0] FB_Y     = 8'h90;
    localparam logic [7:0] FB_X     = 8'h91;
    localparam logic [7:0] FB_COLOR = 8'h92;
    localparam logic [7:0] FB_READ  = 8'h93;

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
    localparam logic [6:0]    X_MAX      = 7'(FB_X_MAX);
    localparam logic [5:0]    Y_MAX      = 6'(FB_Y_MAX);

    // ---------------- write decode ----------------
    logic               wr_kbd_data, wr_kbd_stat, wr_ctrl;
    logic               wr_fb_y, wr_fb_x, wr_fb_color;
    logic [NUM_OUT-1:0] out_wr;

    assign wr_kbd_data = bus.io_strb && (bus.port_id == KBD_DATA);
    assign wr_kbd_stat = bus.io_strb && (bus.port_id == KBD_STAT);
    assign wr_ctrl     = bus.io_strb && (bus.port_id == CTRL);
    assign wr_fb_y     = bus.io_strb && (bus.port_id == FB_Y);
    assign wr_fb_x     = bus.io_strb && (bus.port_id == FB_X);
    assign wr_fb_color = bus.io_strb && (bus.port_id == FB_COLOR);

    always_comb begin
        out_wr = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_wr[k] = bus.io_strb && (bus.port_id == OUT_BASE + 8'(k));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_regs <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (out_wr[k]) out_regs[8*k +: 8] <= bus.out_port;
            end
        end
    end

    // ---------------- control register ----------------
    logic int_en;
    logic auto_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_en   <= 1'b0;
            auto_inc <= 1'b0;
        end else if (wr_ctrl) begin
            int_en   <= bus.out_port[0];
            auto_inc <= bus.out_port[1];
        end
    end

    // ---------------- keyboard FIFO ----------------
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          empty, full, do_push, do_pop, ovf_set, int_fire;
    logic          overflow, intr_q;
    logic [7:0]    kbd_head;

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = wr_kbd_data && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = kbd_valid && (!full || do_pop);
    assign ovf_set  = kbd_valid && full && !do_pop;
    assign kbd_head = empty ? 8'h00 : fifo_mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop)      count_next = count + CW'(1);
        else if (!do_push && do_pop) count_next = count - CW'(1);
    end

    assign int_fire = int_en && ((do_push && empty) || (do_pop && (count_next != '0)));

    always_ff @(posedge clk) begin
        if (do_push) fifo_mem[wr_ptr] <= kbd_code;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            intr_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count  <= count_next;
            intr_q <= int_fire;
            // A drop in the same cycle as a status write leaves the flag set.
            if (ovf_set)          overflow <= 1'b1;
            else if (wr_kbd_stat) overflow <= 1'b0;
        end
    end

    assign bus.intr = intr_q;

    // ---------------- framebuffer port ----------------
    logic [6:0] fb_x;
    logic [5:0] fb_y;
    logic       step;
    logic       x_wrap;

    assign step   = fb_we && auto_inc;
    assign x_wrap = (fb_x >= X_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we <= 1'b0;
            fb_wd <= 8'h00;
            fb_x  <= '0;
            fb_y  <= '0;
        end else begin
            fb_we <= wr_fb_color;
            if (wr_fb_color) fb_wd <= bus.out_port;
            // Explicit coordinate loads take priority over the auto-increment step.
            if (wr_fb_x)      fb_x <= bus.out_port[6:0];
            else if (step)    fb_x <= x_wrap ? 7'd0 : fb_x + 7'd1;
            if (wr_fb_y)             fb_y <= bus.out_port[5:0];
            else if (step && x_wrap) fb_y <= (fb_y >= Y_MAX) ? 6'd0 : fb_y + 6'd1;
        end
    end

    assign fb_wa = {fb_y, fb_x};

    // ---------------- read mux ----------------
    logic [7:0] rd_data;

    always_comb begin
        rd_data = 8'h00;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.port_id == IN_BASE + 8'(k)) rd_data = in_data[8*k +: 8];
        end
        case (bus.port_id)
            KBD_DATA: rd_data = kbd_head;
            KBD_STAT: rd_data = {overflow, 4'b0000, auto_inc, full, !empty};
            CTRL:     rd_data = {6'b000000, auto_inc, int_en};
            FB_READ:  rd_data = fb_rd;
            default:  ;
        endcase
    end

    assign bus.in_port = rd_data;

endmodule

// File: tb/tb_rat_io_port_hub.sv
// Self-checking bench for rat_io_port_hub: directed scenarios plus randomized traffic
// checked cycle by cycle against a queue-based behavioural model.
module tb_rat_io_port_hub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] in_data;
    logic [31:0] out_regs;
    logic        kbd_valid;
    logic [7:0]  kbd_code;
    logic [12:0] fb_wa;
    logic [7:0]  fb_wd;
    logic        fb_we;
    logic [7:0]  fb_rd;

    rat_io_port_hub_if bus ();

    rat_io_port_hub dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus.slave),
        .in_data   (in_data),
        .out_regs  (out_regs),
        .kbd_valid (kbd_valid),
        .kbd_code  (kbd_code),
        .fb_wa     (fb_wa),
        .fb_wd     (fb_wd),
        .fb_we     (fb_we),
        .fb_rd     (fb_rd)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / model state ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  m_out [4];
    logic [7:0]  m_kq [$];
    logic [20:0] exp_q [$];
    bit          m_ovf, m_int_en, m_auto, m_int, m_we;
    int          m_x, m_y;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            if (n_bad <= 40) $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_out[k] = 8'h00;
        m_kq.delete();
        exp_q.delete();
        m_ovf = 0; m_int_en = 0; m_auto = 0; m_int = 0; m_we = 0;
        m_x = 0; m_y = 0;
    endtask

    function automatic logic [7:0] model_in(input logic [7:0] pid);
        int c;
        c = int'(pid) - 32;
        if (c >= 0 && c < 4) return in_data[8*c +: 8];
        case (pid)
            8'h44: return (m_kq.size() > 0) ? m_kq[0] : 8'h00;
            8'h45: return {m_ovf, 4'b0000, m_auto, m_kq.size() == 8, m_kq.size() != 0};
            8'h46: return {6'b000000, m_auto, m_int_en};
            8'h93: return fb_rd;
            default: return 8'h00;
        endcase
    endfunction

    // One clock: advance the model with the currently driven inputs, then check outputs.
    task automatic tick();
        logic        strb;
        logic [7:0]  pid, od;
        int          sz;
        bit          pop, push, ovf_set;
        logic [31:0] exp_out;
        logic [20:0] e;
        strb = bus.io_strb; pid = bus.port_id; od = bus.out_port;
        sz      = m_kq.size();
        pop     = strb && pid == 8'h44 && sz > 0;
        push    = kbd_valid && (sz < 8 || pop);
        ovf_set = kbd_valid && sz == 8 && !pop;
        m_int   = m_int_en && ((push && sz == 0) || (pop && (sz - 1 + int'(push)) > 0));
        if (pop)  void'(m_kq.pop_front());
        if (push) m_kq.push_back(kbd_code);
        if (strb && pid == 8'h45) m_ovf = 0;
        if (ovf_set) m_ovf = 1;
        if (m_we && m_auto) begin
            if (m_x >= 79) begin
                m_x = 0;
                m_y = (m_y >= 59) ? 0 : m_y + 1;
            end else begin
                m_x = m_x + 1;
            end
        end
        if (strb) begin
            if (pid >= 8'h40 && pid <= 8'h43) m_out[pid - 8'h40] = od;
            if (pid == 8'h46) begin m_int_en = od[0]; m_auto = od[1]; end
            if (pid == 8'h90) m_y = int'(od[5:0]);
            if (pid == 8'h91) m_x = int'(od[6:0]);
        end
        m_we = strb && pid == 8'h92;
        if (m_we) exp_q.push_back({6'(m_y), 7'(m_x), od});
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 4; k++) exp_out[8*k +: 8] = m_out[k];
        check("out_regs", out_regs, exp_out);
        check("intr", {31'b0, bus.intr}, {31'b0, m_int});
        check("fb_we", {31'b0, fb_we}, {31'b0, m_we});
        if (m_we) begin
            e = exp_q.pop_front();
            check("fb_write", {11'b0, fb_wa, fb_wd}, {11'b0, e});
        end
        check("in_port", {24'b0, bus.in_port}, {24'b0, model_in(bus.port_id)});
    endtask

    // ---------------- driver tasks ----------------
    task automatic io_write(input logic [7:0] pid, input logic [7:0] data);
        bus.io_strb = 1'b1; bus.port_id = pid; bus.out_port = data;
        tick();
        bus.io_strb = 1'b0;
    endtask

    task automatic kbd_push(input logic [7:0] code);
        kbd_valid = 1'b1; kbd_code = code;
        tick();
        kbd_valid = 1'b0;
    endtask

    task automatic read_const(input string tag, input logic [7:0] pid, input logic [7:0] want);
        bus.port_id = pid;
        #1;
        check(tag, {24'b0, bus.in_port}, {24'b0, want});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- stimulus ----------------
    logic [7:0] id_tab [16];

    initial begin
        id_tab = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h46, 8'h90,
                   8'h91, 8'h92, 8'h93, 8'h20, 8'h21, 8'h23, 8'h44, 8'h7F};
        bus.io_strb = 1'b0; bus.port_id = 8'h00; bus.out_port = 8'h00;
        kbd_valid = 1'b0; kbd_code = 8'h00; in_data = 32'h0; fb_rd = 8'h00;
        model_reset();

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_out_regs", out_regs, 32'h0);
        check("rst_fb_we", {31'b0, fb_we}, 32'h0);
        check("rst_fb_wa", {19'b0, fb_wa}, 32'h0);
        check("rst_intr", {31'b0, bus.intr}, 32'h0);
        read_const("rst_kbd_stat", 8'h45, 8'h00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Output register and input channel
        io_write(8'h41, 8'hA5);
        check("out_41", out_regs, 32'h0000_A500);
        in_data = 32'h003C_0000;
        read_const("in_22", 8'h22, 8'h3C);

        // Single push with interrupt, then pop
        io_write(8'h46, 8'h01);
        kbd_push(8'h1C);
        check("int_push", {31'b0, bus.intr}, 32'h1);
        idle(1);
        check("int_once", {31'b0, bus.intr}, 32'h0);
        read_const("kbd_head", 8'h44, 8'h1C);
        read_const("kbd_stat1", 8'h45, 8'h01);
        io_write(8'h44, 8'h00);
        check("int_last_pop", {31'b0, bus.intr}, 32'h0);
        read_const("kbd_stat0", 8'h45, 8'h00);

        // Overflow, sticky clear, push+pop while full
        io_write(8'h46, 8'h00);
        for (int i = 0; i < 9; i++) kbd_push(8'(8'h60 + i));
        read_const("stat_ovf", 8'h45, 8'h83);
        read_const("head_first", 8'h44, 8'h60);
        io_write(8'h45, 8'h00);
        read_const("stat_clr", 8'h45, 8'h03);
        kbd_valid = 1'b1; kbd_code = 8'h99;
        io_write(8'h44, 8'h00);
        kbd_valid = 1'b0;
        read_const("stat_pp_full", 8'h45, 8'h03);
        read_const("head_after_pp", 8'h44, 8'h61);
        for (int i = 0; i < 8; i++) io_write(8'h44, 8'h00);
        read_const("stat_drained", 8'h45, 8'h00);

        // Framebuffer auto-increment across a row end
        io_write(8'h46, 8'h02);
        io_write(8'h90, 8'd5);
        io_write(8'h91, 8'd79);
        bus.io_strb = 1'b1; bus.port_id = 8'h92; bus.out_port = 8'hE0;
        tick();
        check("fb1_wa", {19'b0, fb_wa}, {19'b0, 6'd5, 7'd79});
        check("fb1_wd", {24'b0, fb_wd}, 32'hE0);
        bus.out_port = 8'h1F;
        tick();
        bus.io_strb = 1'b0;
        check("fb2_we", {31'b0, fb_we}, 32'h1);
        check("fb2_wa", {19'b0, fb_wa}, {19'b0, 6'd6, 7'd0});
        check("fb2_wd", {24'b0, fb_wd}, 32'h1F);
        idle(1);

        // Last pixel wraps to origin
        io_write(8'h90, 8'd59);
        io_write(8'h91, 8'd79);
        io_write(8'h92, 8'h55);
        idle(1);
        check("fb_wrap_origin", {19'b0, fb_wa}, 32'h0);

        // Reset during an FB_WE cycle
        io_write(8'h90, 8'd10);
        io_write(8'h91, 8'd3);
        io_write(8'h92, 8'h77);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'b0, fb_we}, 32'h0);
        check("rst_mid_wa", {19'b0, fb_wa}, 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // Randomized traffic
        io_write(8'h46, 8'h03);
        for (int i = 0; i < 2000; i++) begin
            bus.io_strb  = ($urandom_range(0, 99) < 40);
            bus.port_id  = id_tab[$urandom_range(0, 15)];
            bus.out_port = 8'($urandom);
            if (bus.port_id == 8'h7F) bus.port_id = 8'($urandom);
            kbd_valid = ($urandom_range(0, 99) < ((i % 400 < 200) ? 45 : 8));
            kbd_code  = 8'($urandom);
            if ($urandom_range(0, 9) == 0) in_data = $urandom;
            if ($urandom_range(0, 9) == 0) fb_rd = 8'($urandom);
            tick();
        end
        bus.io_strb = 1'b0;
        kbd_valid   = 1'b0;
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rat_io_port_hub.md
RAT_IO_PORT_HUB -- requirements
Module: rat_io_port_hub

Interface
REQ-001 Parameter NUM_OUT, default 4; number of 8-bit output registers at OUT_BASE..OUT_BASE+NUM_OUT-1.
REQ-002 Parameter OUT_BASE, default 8'h40; first output register port ID.
REQ-003 Parameter NUM_IN, default 4; number of 8-bit input channels at IN_BASE..IN_BASE+NUM_IN-1.
REQ-004 Parameter IN_BASE, default 8'h20; first input channel port ID.
REQ-005 Parameter FIFO_DEPTH, default 8 (power of 2, 2..64); keyboard scancode FIFO entries.
REQ-006 Parameter FB_X_MAX, default 79; FB_Y_MAX, default 59; last valid framebuffer column and row.
REQ-007 Fixed IDs: KBD_DATA 8'h44, KBD_STAT 8'h45, CTRL 8'h46, FB_Y 8'h90, FB_X 8'h91, FB_COLOR 8'h92, FB_READ 8'h93.
REQ-008 CLK  in  1  single clock; all state changes on its rising edge.
REQ-009 RESET_N  in  1  asynchronous, active-low reset.
REQ-010 PORT_ID  in  8  CPU port address.
REQ-011 OUT_PORT  in  8  CPU write data.
REQ-012 IO_STRB  in  1  CPU write strobe, one cycle per OUT instruction.
REQ-013 IN_PORT  out  8  CPU read data, combinational from PORT_ID.
REQ-014 IN_DATA  in  8*NUM_IN  input channels; channel k is bits [8k+7:8k].
REQ-015 OUT_REGS  out  8*NUM_OUT  output register contents, same packing.
REQ-016 KBD_VALID  in  1  one-cycle scancode-available pulse; KBD_CODE  in  8  scancode.
REQ-017 INT  out  1  one-cycle CPU interrupt pulse.
REQ-018 FB_WA  out  13  {Y[5:0], X[6:0]}; FB_WD  out  8  pixel colour; FB_WE  out  1  write enable; FB_RD  in  8  pixel read data.

Function
REQ-019 A write is IO_STRB=1 at a rising edge; PORT_ID selects target; unmapped IDs shall be ignored.
REQ-020 Write to OUT_BASE+k (k<NUM_OUT) shall load OUT_REGS channel k with OUT_PORT.
REQ-021 IN_PORT: IN_BASE+k -> IN_DATA channel k; KBD_DATA -> FIFO head (8'h00 if empty); KBD_STAT -> {overflow,4'b0,auto_inc,full,~empty}; CTRL -> {6'b0,auto_inc,int_en}; FB_READ -> FB_RD; any other ID -> 8'h00.
REQ-022 Write to CTRL shall load int_en=OUT_PORT[0], auto_inc=OUT_PORT[1].
REQ-023 KBD_VALID with FIFO not full shall push KBD_CODE; head visible on IN_PORT the cycle after push into empty FIFO.
REQ-024 Any write to KBD_DATA shall pop the head; pop when empty shall be ignored.
REQ-025 Push and pop in the same cycle shall both succeed, count unchanged, including when full; empty push+pop: push only.
REQ-026 KBD_VALID with FIFO full and no simultaneous pop shall drop the code and set sticky overflow; any write to KBD_STAT clears overflow.
REQ-027 With int_en=1, INT shall pulse one cycle after a push into an empty FIFO, and one cycle after a pop that leaves the FIFO non-empty; never otherwise.
REQ-028 FIFO pointers wrap modulo FIFO_DEPTH; count width clog2(FIFO_DEPTH)+1.
REQ-029 Write to FB_Y loads Y=OUT_PORT[5:0]; write to FB_X loads X=OUT_PORT[6:0]; no range clamping on load.
REQ-030 Write to FB_COLOR shall assert FB_WE for exactly the next cycle with FB_WD=OUT_PORT and FB_WA unchanged during that cycle.
REQ-031 With auto_inc=1, X shall increment at the edge ending the FB_WE cycle; X>=FB_X_MAX wraps to 0 and increments Y; Y>=FB_Y_MAX with X wrap wraps Y to 0.
REQ-032 Back-to-back FB_COLOR writes on consecutive strobes shall each produce one FB_WE pulse at successive addresses when auto_inc=1.

Reset
REQ-033 RESET_N=0 shall immediately clear OUT_REGS, FIFO (empty, pointers 0), overflow, int_en, auto_inc, X, Y, FB_WD, FB_WE, INT, independent of CLK.
REQ-034 Reset asserted mid-FB_WE or mid-push shall abort the operation; no FB_WE or INT after release until new stimulus.

Verification
REQ-035 Write 8'hA5 to 8'h41 -> OUT_REGS[15:8]=8'hA5, others 0; read 8'h22 with IN_DATA[23:16]=8'h3C -> IN_PORT=8'h3C.
REQ-036 int_en=1; push 8'h1C into empty FIFO -> INT one pulse, KBD_DATA reads 8'h1C, KBD_STAT=8'h01; write KBD_DATA -> KBD_STAT=8'h00, no INT.
REQ-037 Push 9 codes (depth 8) -> first 8 kept, KBD_STAT=8'h83; write KBD_STAT -> 8'h03; push+pop same cycle while full -> still full, no overflow.
REQ-038 auto_inc=1, Y=5, X=79, two FB_COLOR writes 8'hE0,8'h1F -> FB_WE at WA={6'd5,7'd79} data E0, then {6'd6,7'd0} data 1F.
REQ-039 Y=59, X=79, auto_inc=1, one FB_COLOR write -> next address Y=0, X=0.
REQ-040 Drop RESET_N during FB_WE cycle -> FB_WE=0, X=Y=0 at once; no further write after release.
